// File: rtl/main_fsm.sv
// ---------------------------------------------------------------------------
// main_fsm
// Multicycle instruction sequencer for the RV32I core. It holds the
// instruction-level state machine and drives every datapath strobe and mux
// select. It decodes the opcode and the branch condition from the captured
// instruction and the ALU flags.
//
// Ports
//   clk, reset        core clock, asynchronous active-high reset
//   op, funct3        opcode and funct3 fields of the instruction register
//   zero, carry,      ALU flags (carry=1 means a>=b unsigned)
//   sign, overflow
//   pc_write          load PC from result
//   adr_src           memory address source (0 PC, 1 result)
//   ir_write          capture instruction and old_pc
//   mem_write         data memory write enable
//   reg_write         register file write enable
//   result_src        result mux (00 alu_reg, 01 data reg, 10 alu_result)
//   alu_src_a         ALU A mux (00 pc, 01 old_pc, 10 rd1)
//   alu_src_b         ALU B mux (00 rd2, 01 imm_ext, 10 constant 4)
//   alu_op            00 add, 01 sub/compare, 10 funct-decoded, 11 pass B
//   imm_src           immediate format (000 I, 001 S, 010 B, 011 U, 100 J)
//   halted            illegal instruction trapped
//   state             current state code (debug)
//   instret           retired-instruction count
// ---------------------------------------------------------------------------
module main_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic        zero,
  input  logic        carry,
  input  logic        sign,
  input  logic        overflow,
  output logic        pc_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        mem_write,
  output logic        reg_write,
  output logic [1:0]  result_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [2:0]  imm_src,
  output logic        halted,
  output logic [3:0]  state,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEMADR    = 4'd2,
    MEMREAD   = 4'd3,
    MEMWB     = 4'd4,
    MEMWRITE  = 4'd5,
    EXECR     = 4'd6,
    EXECI     = 4'd7,
    ALUWB     = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    JALR_LINK = 4'd12,
    LUI       = 4'd13,
    AUIPC     = 4'd14,
    HALT      = 4'd15
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  stateT       state_q, state_d;
  logic [31:0] instret_q;
  logic        enterFetch;
  logic        branchTaken;

  logic        pcWriteState;
  logic        irWriteState;
  logic        memWriteState;
  logic        regWriteState;

  // Next-state decode. DECODE dispatches on the opcode; funct3 010/011 are
  // not defined for branches, so they trap like any unknown opcode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:     state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? HALT : BRANCH;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = JALR;
          OP_LUI:            state_d = LUI;
          OP_AUIPC:          state_d = AUIPC;
          default:           state_d = HALT;
        endcase
      end
      MEMADR:    state_d = (op == OP_STORE) ? MEMWRITE : MEMREAD;
      MEMREAD:   state_d = MEMWB;
      MEMWB:     state_d = FETCH;
      MEMWRITE:  state_d = FETCH;
      EXECR:     state_d = ALUWB;
      EXECI:     state_d = ALUWB;
      ALUWB:     state_d = FETCH;
      BRANCH:    state_d = FETCH;
      JAL:       state_d = ALUWB;
      JALR:      state_d = JALR_LINK;
      JALR_LINK: state_d = ALUWB;
      LUI:       state_d = ALUWB;
      AUIPC:     state_d = ALUWB;
      HALT:      state_d = HALT;
      default:   state_d = HALT;
    endcase
  end

  // An instruction retires exactly when the machine re-enters FETCH from
  // some other state; FETCH itself always moves on to DECODE.
  assign enterFetch = (state_d == FETCH) && (state_q != FETCH);

  // State register and retired-instruction counter. Reset aborts whatever
  // instruction is in flight and restarts at FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (enterFetch) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  // Branch condition from the flags present in the BRANCH cycle. The ALU
  // computes rd1 - rd2, so carry means "no borrow", i.e. unsigned >=.
  always_comb begin
    branchTaken = 1'b0;
    case (funct3)
      3'b000:  branchTaken = zero;
      3'b001:  branchTaken = ~zero;
      3'b100:  branchTaken = sign ^ overflow;
      3'b101:  branchTaken = ~(sign ^ overflow);
      3'b110:  branchTaken = ~carry;
      3'b111:  branchTaken = carry;
      default: branchTaken = 1'b0;
    endcase
  end

  // Moore strobes and selects per state. The write strobes are collected
  // separately so that reset can mask them below.
  always_comb begin
    pcWriteState  = 1'b0;
    irWriteState  = 1'b0;
    memWriteState = 1'b0;
    regWriteState = 1'b0;
    adr_src       = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    case (state_q)
      FETCH: begin
        irWriteState = 1'b1;
        pcWriteState = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        adr_src = 1'b1;
      end
      MEMWB: begin
        result_src    = 2'b01;
        regWriteState = 1'b1;
      end
      MEMWRITE: begin
        adr_src       = 1'b1;
        memWriteState = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: begin
        regWriteState = 1'b1;
      end
      BRANCH: begin
        alu_src_a    = 2'b10;
        alu_op       = 2'b01;
        pcWriteState = branchTaken;
      end
      JAL, JALR_LINK: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pcWriteState = 1'b1;
      end
      JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      LUI: begin
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
      end
      AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      default: begin
      end
    endcase
  end

  // Immediate format follows the opcode in every state so the extender is
  // already correct when DECODE forms the branch/JAL target.
  always_comb begin
    imm_src = 3'b000;
    case (op)
      OP_STORE:          imm_src = 3'b001;
      OP_BRANCH:         imm_src = 3'b010;
      OP_LUI, OP_AUIPC:  imm_src = 3'b011;
      OP_JAL:            imm_src = 3'b100;
      default:           imm_src = 3'b000;
    endcase
  end

  // Architectural writes are masked while reset is held so nothing is
  // committed between the asserting edge and the restart at FETCH.
  assign pc_write  = pcWriteState  & ~reset;
  assign ir_write  = irWriteState  & ~reset;
  assign mem_write = memWriteState & ~reset;
  assign reg_write = regWriteState & ~reset;

  assign halted  = (state_q == HALT);
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_main_fsm.sv
// ---------------------------------------------------------------------------
// tb_main_fsm
// Directed testbench for main_fsm. Each instruction is described by its
// opcode, funct3, flags, expected state walk and branch outcome; strobes in
// every state are compared with the state table from the sequencer's
// description, and instret is tracked by hand.
// ---------------------------------------------------------------------------
module tb_main_fsm;

  logic        clk;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        zero, carry, sign, overflow;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0]  result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0]  imm_src;
  logic        halted;
  logic [3:0]  state;
  logic [31:0] instret;

  logic [14:0] obsVec;
  int          checkCount;
  int          errorCount;
  logic [31:0] instretExp;

  main_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .zero       (zero),
    .carry      (carry),
    .sign       (sign),
    .overflow   (overflow),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .ir_write   (ir_write),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .halted     (halted),
    .state      (state),
    .instret    (instret)
  );

  // 10 ns clock, rising edge active.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign obsVec = {pc_write, adr_src, ir_write, mem_write, reg_write,
                   result_src, alu_src_a, alu_src_b, alu_op, halted};

  // Expected strobe vector per state, packed as obsVec.
  function automatic logic [14:0] expStrobes(input logic [3:0] s, input logic taken);
    logic pc, adr, ir, mw, rw, h;
    logic [1:0] rs, a, b, aop;
    pc = 0; adr = 0; ir = 0; mw = 0; rw = 0; h = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
    case (s)
      4'd0:  begin ir = 1; pc = 1; b = 2'b10; rs = 2'b10; end
      4'd1:  begin a = 2'b01; b = 2'b01; end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  begin adr = 1; end
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin a = 2'b10; aop = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      4'd8:  begin rw = 1; end
      4'd9:  begin a = 2'b10; aop = 2'b01; pc = taken; end
      4'd10: begin a = 2'b01; b = 2'b10; pc = 1; end
      4'd11: begin a = 2'b10; b = 2'b01; end
      4'd12: begin a = 2'b01; b = 2'b10; pc = 1; end
      4'd13: begin b = 2'b01; aop = 2'b11; end
      4'd14: begin a = 2'b01; b = 2'b01; end
      default: begin h = 1; end
    endcase
    return {pc, adr, ir, mw, rw, rs, a, b, aop, h};
  endfunction

  function automatic logic [2:0] expImm(input logic [6:0] o);
    case (o)
      7'b0100011:             return 3'b001;
      7'b1100011:             return 3'b010;
      7'b0110111, 7'b0010111: return 3'b011;
      7'b1101111:             return 3'b100;
      default:                return 3'b000;
    endcase
  endfunction

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive instruction fields and ALU flags ({zero,carry,sign,overflow}).
  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f,
                               input logic [3:0] flags);
    op     = o;
    funct3 = f;
    {zero, carry, sign, overflow} = flags;
  endtask

  // Walk one instruction from FETCH. seq holds the expected states, one
  // nibble per cycle starting at bit 0; n is the number of cycles.
  task automatic runInstr(input string tag, input logic [6:0] o, input logic [2:0] f,
                          input logic [3:0] flags, input logic [31:0] seq,
                          input int n, input logic taken);
    logic [3:0] s;
    logic [3:0] last;
    last = 4'd0;
    applyStimulus(o, f, flags);
    #1;
    for (int i = 0; i < n; i++) begin
      s = seq[4*i +: 4];
      last = s;
      checkOutput({tag, "_state"},   {60'd0, state}, {60'd0, s});
      checkOutput({tag, "_strobes"}, {49'd0, obsVec}, {49'd0, expStrobes(s, taken)});
      checkOutput({tag, "_imm"},     {61'd0, imm_src}, {61'd0, expImm(o)});
      checkOutput({tag, "_instret"}, {32'd0, instret}, {32'd0, instretExp});
      @(negedge clk);
      #1;
    end
    if (last != 4'd15) begin
      instretExp = instretExp + 32'd1;
      checkOutput({tag, "_end_state"},   {60'd0, state},  64'd0);
      checkOutput({tag, "_end_instret"}, {32'd0, instret}, {32'd0, instretExp});
    end else begin
      checkOutput({tag, "_end_state"}, {60'd0, state}, 64'd15);
    end
  endtask

  // Assert reset for one clock edge and release it at a falling edge.
  task automatic pulseReset(input string tag);
    reset = 1'b1;
    #1;
    checkOutput({tag, "_rst_state"},   {60'd0, state}, 64'd0);
    checkOutput({tag, "_rst_instret"}, {32'd0, instret}, 64'd0);
    checkOutput({tag, "_rst_writes"},  {60'd0, pc_write, ir_write, mem_write, reg_write}, 64'd0);
    checkOutput({tag, "_rst_halted"},  {63'd0, halted}, 64'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_rst_hold_writes"}, {60'd0, pc_write, ir_write, mem_write, reg_write}, 64'd0);
    checkOutput({tag, "_rst_hold_state"},  {60'd0, state}, 64'd0);
    reset = 1'b0;
    instretExp = 32'd0;
    #1;
    checkOutput({tag, "_post_fetch"}, {62'd0, pc_write, ir_write}, 64'd3);
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    instretExp = 32'd0;
    reset      = 1'b1;
    applyStimulus(7'b0110011, 3'b000, 4'b0000);

    // Power-on reset state.
    @(negedge clk);
    #1;
    checkOutput("por_state",   {60'd0, state}, 64'd0);
    checkOutput("por_instret", {32'd0, instret}, 64'd0);
    checkOutput("por_writes",  {60'd0, pc_write, ir_write, mem_write, reg_write}, 64'd0);
    checkOutput("por_halted",  {63'd0, halted}, 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("por_first_fetch", {62'd0, pc_write, ir_write}, 64'd3);

    // R-type add.
    runInstr("add", 7'b0110011, 3'b000, 4'b0000, 32'h8610, 4, 1'b0);

    // Second add interrupted by reset while in EXECR.
    applyStimulus(7'b0110011, 3'b000, 4'b0000);
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    checkOutput("midexec_state", {60'd0, state}, 64'd6);
    pulseReset("midexec");

    // Load then store.
    runInstr("lw", 7'b0000011, 3'b010, 4'b0000, 32'h43210, 5, 1'b0);
    runInstr("sw", 7'b0100011, 3'b010, 4'b0000, 32'h5210, 4, 1'b0);

    // Branches: {zero,carry,sign,overflow}.
    runInstr("beq_t",  7'b1100011, 3'b000, 4'b1000, 32'h910, 3, 1'b1);
    runInstr("bne_nt", 7'b1100011, 3'b001, 4'b1000, 32'h910, 3, 1'b0);
    runInstr("bltu_t", 7'b1100011, 3'b110, 4'b0000, 32'h910, 3, 1'b1);
    runInstr("bgeu_nt",7'b1100011, 3'b111, 4'b0000, 32'h910, 3, 1'b0);
    runInstr("blt_nt", 7'b1100011, 3'b100, 4'b0011, 32'h910, 3, 1'b0);
    runInstr("bge_t",  7'b1100011, 3'b101, 4'b0011, 32'h910, 3, 1'b1);
    runInstr("bge_nt", 7'b1100011, 3'b101, 4'b0010, 32'h910, 3, 1'b0);

    // Remaining instruction classes.
    runInstr("addi",  7'b0010011, 3'b000, 4'b0000, 32'h8710, 4, 1'b0);
    runInstr("jal",   7'b1101111, 3'b000, 4'b0000, 32'h8A10, 4, 1'b0);
    runInstr("lui",   7'b0110111, 3'b000, 4'b0000, 32'h8D10, 4, 1'b0);
    runInstr("auipc", 7'b0010111, 3'b000, 4'b0000, 32'h8E10, 4, 1'b0);

    // Undefined branch funct3 traps.
    runInstr("bad_br", 7'b1100011, 3'b010, 4'b1000, 32'hF10, 3, 1'b0);
    checkOutput("bad_br_halted", {63'd0, halted}, 64'd1);
    pulseReset("bad_br");

    // Illegal opcode: HALT must hold for 100 cycles with no strobes.
    runInstr("op0", 7'b0000000, 3'b000, 4'b0000, 32'hF10, 3, 1'b0);
    for (int c = 0; c < 100; c++) begin
      checkOutput("halt_hold", {17'd0, state, obsVec, 28'd0},
                  {17'd0, 4'd15, expStrobes(4'd15, 1'b0), 28'd0});
      @(negedge clk);
      #1;
    end
    checkOutput("halt_instret", {32'd0, instret}, 64'd0);
    pulseReset("halt");
    checkOutput("halt_cleared", {63'd0, halted}, 64'd0);

    // JALR after recovery.
    runInstr("jalr", 7'b1100111, 3'b000, 4'b0000, 32'h8CB10, 5, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle sequencer for the RV32I core. It holds the instruction-level state machine and drives every datapath strobe and mux select: PC update, instruction-register capture, memory address source, ALU operand selects, result mux and register-file write. It decodes the opcode and branch condition from the captured instruction and the ALU flags. It sits beside the ALU decoder in the top level and replaces hand-wired strobes.

## Interface
- No parameters.
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- zero, carry, sign, overflow  in  1 each  ALU flags; carry=1 means a>=b unsigned (no borrow on a-b)
- pc_write  out  1  load PC from result
- adr_src  out  1  0=PC, 1=result drives memory address
- ir_write  out  1  capture instruction and old_pc
- mem_write  out  1  data memory write enable
- reg_write  out  1  register file write enable
- result_src  out  2  00 alu_reg, 01 data reg, 10 alu_result
- alu_src_a  out  2  00 pc, 01 old_pc, 10 rd1
- alu_src_b  out  2  00 rd2, 01 imm_ext, 10 constant 4
- alu_op  out  2  00 add, 01 subtract/compare, 10 funct-decoded, 11 pass src_b
- imm_src  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- halted  out  1  illegal instruction trapped
- state  out  4  current state code (debug)
- instret  out  32  retired-instruction count

## Operation
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALR_LINK 12, LUI 13, AUIPC 14, HALT 15.
- Moore outputs come from state, with these exceptions: pc_write in BRANCH depends on the flags; imm_src is decoded from op in every state. Any unlisted strobe is 0 and any unlisted select is 00.
- FETCH: adr_src=0, ir_write=1, a=00, b=10, alu_op=00, result_src=10, pc_write=1 → DECODE.
- DECODE: a=01, b=01, alu_op=00. This places the branch/JAL target in alu_reg. Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH, but funct3 010/011 → HALT
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - anything else → HALT
- MEMADR: a=10, b=01, alu_op=00 → MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: adr_src=1, result_src=00 → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 → FETCH.
- EXECR: a=10, b=00, alu_op=10 → ALUWB.
- EXECI: a=10, b=01, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=taken → FETCH. Taken by funct3:
  - 000 zero
  - 001 !zero
  - 100 sign^overflow
  - 101 !(sign^overflow)
  - 110 !carry
  - 111 carry
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB. Link is old_pc+4.
- JALR: a=10, b=01, alu_op=00 → JALR_LINK.
- JALR_LINK: a=01, b=10, alu_op=00, result_src=00, pc_write=1 → ALUWB. Bit-0 masking of the target is done by the datapath.
- LUI: b=01, alu_op=11 → ALUWB.
- AUIPC: a=01, b=01, alu_op=00 → ALUWB.
- HALT: all strobes 0, halted=1. Stays in HALT until reset.
- instret increments by 1 on every transition into FETCH from any state other than FETCH. It wraps 0xFFFFFFFF→0.

## Timing
- Reset: state=FETCH, instret=0, halted=0.
- While reset is high, pc_write, ir_write, mem_write and reg_write are forced to 0.
- Reset asserted mid-instruction aborts it immediately; there is no partial writeback after the asserting edge.
- The first FETCH strobes occur in the first cycle after reset deasserts.
- Cycles per instruction, FETCH through last state:
  - branch 3
  - R, I, store, JAL, LUI, AUIPC 4
  - load, JALR 5
- Branch flags are sampled in the BRANCH cycle; pc_write is combinational from them within that cycle.
- The instret increment and the FETCH entry happen on the same edge.

## Test plan
- Reset pulse mid-EXECR → state=0, instret=0, all write strobes 0 during reset, FETCH strobes on the next cycle.
- add (op 0110011) → state sequence 0,1,6,8,0; reg_write high only in state 8; instret +1 after 4 cycles.
- lw then sw → lw visits 0,1,2,3,4 with result_src=01 in state 4; sw visits 0,1,2,5 with mem_write=1 and adr_src=1 in state 5 only.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq, 0 for bne; both return to FETCH after 3 cycles.
- bltu with carry=0, bgeu with carry=0 → taken, not taken. blt with sign=1, overflow=1 → not taken.
- op 0000000, then reset → halted=1 and state=15 held for 100 cycles with no strobes; reset clears halted; jalr then completes via 0,1,11,12,8.
